// File: rtl/sort_pkg.sv
// Types and constants shared between the bubblesort block and its result streamer.
package sort_pkg;

    localparam int N_WORDS = 10;
    localparam int WORD_W  = 16;
    localparam int IDX_W   = $clog2(N_WORDS + 1);

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STREAM  = 2'd2,
        FIN     = 2'd3
    } state_t;

endpackage

// File: rtl/sort_result_streamer_if.sv
// Valid/ready word stream leaving the sort result streamer.
interface sort_result_streamer_if #(
    parameter int W  = sort_pkg::WORD_W,
    parameter int CW = sort_pkg::IDX_W
);

    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic [CW-1:0] out_idx;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        input  out_idx,
        output out_ready
    );

endinterface

// File: rtl/sort_order_checker.sv
// Watches accepted stream words and raises a sticky flag when one is smaller than its predecessor.
module sort_order_checker
    import sort_pkg::*;
#(
    parameter int W  = WORD_W,
    parameter int CW = IDX_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          hs_i,
    input  logic [CW-1:0] idx_i,
    input  logic [W-1:0]  word_i,
    output logic          sort_err_o
);

    logic [W-1:0] prev_q, prev_d;
    logic         err_q, err_d;

    always_comb begin
        // NOTE: every _d starts from its _q so no branch below can leave it unassigned (no latch).
        prev_d = prev_q;
        err_d  = err_q;
        if (clear_i) begin
            prev_d = '0;
            err_d  = 1'b0;
        end else if (hs_i) begin
            prev_d = word_i;
            // Index 0 has no predecessor; equal neighbours are legal.
            if ((idx_i != '0) && (word_i < prev_q)) begin
                err_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            err_q  <= err_d;
        end
    end

    assign sort_err_o = err_q;

endmodule

// File: rtl/sort_result_streamer.sv
// Captures the sorter's N words on done and replays them, lowest index first, on a valid/ready stream.
module sort_result_streamer
    import sort_pkg::*;
#(
    parameter int N  = N_WORDS,
    parameter int W  = WORD_W,
    parameter int CW = IDX_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   done,
    input  logic [N*W-1:0]         dat_in,
    output logic                   rd_en,
    sort_result_streamer_if.master strm,
    output logic                   stream_done,
    output logic                   sort_err,
    input  logic                   clear
);

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t        state_q, state_d;
    logic          rd_en_q, rd_en_d;
    logic          valid_q, valid_d;
    logic [W-1:0]  data_q, data_d;
    logic          last_q, last_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          sdone_q, sdone_d;
    logic [W-1:0]  buf_q [N];
    logic          handshake;

    assign handshake = valid_q & strm.out_ready;

    always_comb begin
        state_d = state_q;
        rd_en_d = 1'b0;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        idx_d   = idx_q;
        sdone_d = sdone_q;
        if (clear) begin
            state_d = IDLE;
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
            idx_d   = '0;
            sdone_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (done) begin
                        state_d = CAPTURE;
                        rd_en_d = 1'b1;
                    end
                end
                CAPTURE: begin
                    // Word 0 comes straight from dat_in since the buffer is written on this same edge.
                    state_d = STREAM;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    data_d  = dat_in[W-1:0];
                    last_d  = (LAST_IDX == '0);
                end
                STREAM: begin
                    if (handshake) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = FIN;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            sdone_d = 1'b1;
                        end else begin
                            idx_d  = idx_q + ONE;
                            data_d = buf_q[idx_q + ONE];
                            last_d = ((idx_q + ONE) == LAST_IDX);
                        end
                    end
                end
                FIN: begin
                    // Held until clear; done is deliberately ignored here.
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            sdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            sdone_q <= sdone_d;
        end
    end

    // NOTE: the capture buffer has no reset; it is always written in CAPTURE before STREAM reads it.
    always_ff @(posedge clk) begin
        if (state_q == CAPTURE) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= dat_in[W*i +: W];
            end
        end
    end

    sort_order_checker #(
        .W  (W),
        .CW (CW)
    ) u_checker (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (clear),
        .hs_i       (handshake),
        .idx_i      (idx_q),
        .word_i     (data_q),
        .sort_err_o (sort_err)
    );

    assign rd_en          = rd_en_q;
    assign stream_done    = sdone_q;
    assign strm.out_valid = valid_q;
    assign strm.out_data  = data_q;
    assign strm.out_last  = last_q;
    assign strm.out_idx   = idx_q;

endmodule

// File: tb/tb_sort_result_streamer.sv
// Self-checking bench for sort_result_streamer: table vectors, corner sequences and random loads.
module tb_sort_result_streamer;
    import sort_pkg::*;

    localparam int N  = N_WORDS;
    localparam int W  = WORD_W;
    localparam int CW = IDX_W;

    typedef struct packed {
        logic [N*W-1:0] words;
        logic [1:0]     mode;     // 0: ready high, 1: ready 1,0,0 pattern, 2: random ready
        logic           exp_err;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           done;
    logic           clear;
    logic [N*W-1:0] dat_in;
    logic           rd_en;
    logic           stream_done;
    logic           sort_err;

    int n_checks = 0;
    int n_fail   = 0;

    word_t          tmp [N];
    vec_t           vecs [6];
    logic [N*W-1:0] p;
    int             guard;

    sort_result_streamer_if #(.W(W), .CW(CW)) strm ();

    sort_result_streamer #(.N(N), .W(W), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .done        (done),
        .dat_in      (dat_in),
        .rd_en       (rd_en),
        .strm        (strm),
        .stream_done (stream_done),
        .sort_err    (sort_err),
        .clear       (clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input word_t a [N]);
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[W*i +: W] = a[i];
        return r;
    endfunction

    function automatic word_t wd(input logic [N*W-1:0] v, input int i);
        return v[W*i +: W];
    endfunction

    // Reference: the load is in order iff no word is below the one before it.
    function automatic logic model_err(input logic [N*W-1:0] v);
        for (int i = 1; i < N; i++) begin
            if (wd(v, i) < wd(v, i - 1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rd_en"},       32'(rd_en), 0);
        check({tag, " out_valid"},   32'(strm.out_valid), 0);
        check({tag, " out_last"},    32'(strm.out_last), 0);
        check({tag, " stream_done"}, 32'(stream_done), 0);
        check({tag, " sort_err"},    32'(sort_err), 0);
        check({tag, " out_idx"},     32'(strm.out_idx), 0);
        check({tag, " out_data"},    32'(strm.out_data), 0);
    endtask

    task automatic clear_pulse(input string tag);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check({tag, " clear stream_done"}, 32'(stream_done), 0);
        check({tag, " clear sort_err"},    32'(sort_err), 0);
        check({tag, " clear out_valid"},   32'(strm.out_valid), 0);
        check({tag, " clear out_idx"},     32'(strm.out_idx), 0);
        check({tag, " clear rd_en"},       32'(rd_en), 0);
    endtask

    // Loads v, raises done and drains the whole stream, checking every offered word.
    task automatic run_stream(input logic [N*W-1:0] v, input int mode, input string tag,
                              input logic exp_err);
        int   cnt       = 0;
        int   cyc       = 0;
        int   rd_pulses = 0;
        logic merr      = 1'b0;
        logic rdy;
        dat_in         = v;
        done           = 1'b1;
        strm.out_ready = 1'b0;
        tick();
        check({tag, " rd_en rises"}, 32'(rd_en), 1);
        check({tag, " no valid in capture"}, 32'(strm.out_valid), 0);
        tick();
        check({tag, " rd_en single cycle"}, 32'(rd_en), 0);
        while (cyc < 300 && !stream_done) begin
            if (rd_en) rd_pulses++;
            check({tag, " sort_err"},  32'(sort_err), 32'(merr));
            check({tag, " out_valid"}, 32'(strm.out_valid), 32'(cnt < N));
            if (strm.out_valid && cnt < N) begin
                check({tag, " out_data"}, 32'(strm.out_data), 32'(wd(v, cnt)));
                check({tag, " out_idx"},  32'(strm.out_idx), 32'(cnt));
                check({tag, " out_last"}, 32'(strm.out_last), 32'(cnt == N - 1));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            strm.out_ready = rdy;
            if (strm.out_valid && rdy && cnt < N) begin
                if (cnt > 0 && wd(v, cnt) < wd(v, cnt - 1)) merr = 1'b1;
                cnt++;
            end
            tick();
            cyc++;
        end
        strm.out_ready = 1'b0;
        check({tag, " handshake count"}, 32'(cnt), N);
        check({tag, " stream_done"},     32'(stream_done), 1);
        check({tag, " valid off in FIN"}, 32'(strm.out_valid), 0);
        check({tag, " final sort_err"},  32'(sort_err), 32'(exp_err));
        check({tag, " no extra rd_en"},  32'(rd_pulses), 0);
        if (mode == 0) check({tag, " back-to-back cycles"}, 32'(cyc), N);
    endtask

    // done stays high in FIN: no recapture, flags hold.
    task automatic fin_hold(input string tag, input logic exp_err);
        repeat (3) begin
            tick();
            check({tag, " FIN rd_en"},       32'(rd_en), 0);
            check({tag, " FIN stream_done"}, 32'(stream_done), 1);
            check({tag, " FIN sort_err"},    32'(sort_err), 32'(exp_err));
        end
    endtask

    initial begin
        reset          = 1'b0;
        done           = 1'b0;
        clear          = 1'b0;
        dat_in         = '0;
        strm.out_ready = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();
        check("idle without done rd_en", 32'(rd_en), 0);

        tmp = '{16'h0001, 16'h0002, 16'h0003, 16'h0010, 16'h0010,
                16'h0050, 16'h0050, 16'h0100, 16'h0300, 16'h0500};
        vecs[0] = '{words: pack(tmp), mode: 2'd0, exp_err: 1'b0};
        vecs[1] = '{words: pack(tmp), mode: 2'd1, exp_err: 1'b0};
        tmp = '{16'd1, 16'd2, 16'd5, 16'd3, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11};
        vecs[2] = '{words: pack(tmp), mode: 2'd0, exp_err: 1'b1};
        tmp = '{default: 16'h0007};
        vecs[3] = '{words: pack(tmp), mode: 2'd1, exp_err: 1'b0};
        tmp = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'hFFFF, 16'h0000};
        vecs[4] = '{words: pack(tmp), mode: 2'd2, exp_err: 1'b1};
        tmp = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[5] = '{words: pack(tmp), mode: 2'd2, exp_err: 1'b0};

        // Each clear after the first arrives with done still high, so restart follows at once.
        for (int k = 0; k < 6; k++) begin
            clear_pulse($sformatf("vec%0d", k));
            run_stream(vecs[k].words, int'(vecs[k].mode), $sformatf("vec%0d", k), vecs[k].exp_err);
            fin_hold($sformatf("vec%0d", k), vecs[k].exp_err);
        end

        // Asynchronous reset while word 4 is offered.
        clear_pulse("rst");
        dat_in = vecs[0].words;
        done   = 1'b1;
        tick();
        tick();
        strm.out_ready = 1'b1;
        repeat (4) tick();
        check("rst pre idx", 32'(strm.out_idx), 4);
        reset = 1'b0;
        #1;
        check_all_zero("rst async");
        done           = 1'b0;
        strm.out_ready = 1'b0;
        tick();
        #3;
        reset = 1'b1;
        repeat (3) begin
            tick();
            check("rst after release valid", 32'(strm.out_valid), 0);
            check("rst after release rd_en", 32'(rd_en), 0);
        end
        run_stream(vecs[0].words, 0, "rst restart", 1'b0);

        // clear in the middle of a stream, at index 6.
        clear_pulse("midclr");
        dat_in = vecs[0].words;
        done   = 1'b1;
        tick();
        tick();
        strm.out_ready = 1'b1;
        guard = 0;
        while (!(strm.out_valid && strm.out_idx == CW'(6)) && guard < 30) begin
            tick();
            guard++;
        end
        check("midclr reached idx 6", 32'(guard < 30), 1);
        clear = 1'b1;
        done  = 1'b0;
        tick();
        clear = 1'b0;
        check("midclr out_valid", 32'(strm.out_valid), 0);
        check("midclr stream_done", 32'(stream_done), 0);
        check("midclr out_idx", 32'(strm.out_idx), 0);
        repeat (2) begin
            tick();
            check("midclr idle valid", 32'(strm.out_valid), 0);
            check("midclr idle rd_en", 32'(rd_en), 0);
        end
        strm.out_ready = 1'b0;

        // Random loads: alternate guaranteed-sorted ramps with unconstrained words.
        for (int r = 0; r < 8; r++) begin
            tmp[0] = word_t'($urandom_range(0, 1000));
            for (int i = 1; i < N; i++) begin
                tmp[i] = (r % 2 == 0) ? tmp[i-1] + word_t'($urandom_range(0, 40))
                                      : word_t'($urandom);
            end
            p = pack(tmp);
            clear_pulse($sformatf("rand%0d", r));
            run_stream(p, 2, $sformatf("rand%0d", r), model_err(p));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sort_result_streamer.md
Name: sort_result_streamer

Overview:
Downstream stage of the bubblesort block. It waits for the sorter's done and pulses rd_en for one cycle to capture the N sorted words. It then emits the words one per handshake on a valid/ready stream, lowest index first. While streaming it checks that the sequence is non-decreasing and raises a sticky error flag if not.

Parameters:
N, 10, number of words captured from the sorter (matches dat_out0..dat_out9)
W, 16, word width in bits
CW, 4, width of index/count (must satisfy 2**CW > N)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
done  input  1  sorter done; sorted data on dat_in is valid while high
dat_in  input  N*W  sorter outputs, flattened; dat_in[W*i +: W] = dat_out<i>
rd_en  output  1  registered read strobe to sorter; one-cycle pulse
out_valid  output  1  stream word valid
out_ready  input  1  downstream accepts word
out_data  output  W  current stream word
out_last  output  1  high with the final word (index N-1)
out_idx  output  CW  index of the word on out_data
stream_done  output  1  all N words accepted; held until clear
sort_err  output  1  sticky; a word was smaller than its predecessor
clear  input  1  synchronous restart: return to IDLE, clear sort_err and stream_done

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; rd_en, out_valid, out_last, stream_done, sort_err=0; out_idx=0; out_data=0; buffer contents don't-care. Reset mid-stream abandons the transfer with no further outputs.
- States: IDLE, CAPTURE, STREAM, FIN.
- IDLE: if done==1 -> CAPTURE, with rd_en=1 registered for the next cycle. Otherwise stay.
- CAPTURE (rd_en==1 this cycle): latch all N words of dat_in into the internal buffer at the clock edge. Next cycle: rd_en=0, idx=0, state=STREAM. If done has dropped in CAPTURE, capture anyway; the sorter contract holds data stable while done is high.
- STREAM: out_valid=1, out_data=buf[idx], out_idx=idx, out_last=(idx==N-1).
  - Handshake = out_valid & out_ready. On a handshake with idx<N-1: idx+1.
  - On a handshake with idx==N-1: state=FIN.
  - Without ready: out_data, out_idx and out_last are held stable (no change while valid and not ready).
- Order check: on each handshake with idx>0, if buf[idx] < buf[idx-1] (unsigned W-bit compare), set sort_err=1. It stays 1 until reset or clear. Equal words are legal.
- FIN: out_valid=0, stream_done=1. done is ignored; no recapture until clear.
- clear: synchronous, highest priority after reset, effective in any state. Next state IDLE; rd_en, out_valid, stream_done, sort_err=0; idx=0. If clear and done arrive together in IDLE, clear wins and done is re-evaluated next cycle.
- Latency:
  - done high in IDLE at edge k -> rd_en high in cycle k+1 -> first out_valid in cycle k+2.
  - With out_ready held high: N words in N consecutive cycles; stream_done rises the cycle after the last handshake.
- Every output is a register; no combinational path from inputs to outputs.

Decomposition:
- Shared package sort_pkg:
  - state enum {IDLE, CAPTURE, STREAM, FIN}
  - constants N_WORDS=10, WORD_W=16
  - a word typedef shared with the bubblesort block
- Natural sub-module: sort_order_checker. It holds the previous word register plus the compare, takes handshake/idx/word, and produces the sticky sort_err. It is cleared by reset/clear.

Test Plan:
1. Sorted load {1,2,3,0x10,0x10,0x50,0x50,0x100,0x300,0x500}, done rises, out_ready=1 -> rd_en pulses exactly 1 cycle; words stream in that order over 10 consecutive cycles; out_last only with 0x500; stream_done=1; sort_err=0.
2. Same data, out_ready toggling 1,0,0,1,... -> no word dropped or duplicated; out_data/out_idx stable during stalls; total 10 handshakes.
3. Unsorted load {1,2,5,3,...} -> sort_err rises on the handshake of index 3 (value 3), stays 1 through FIN, and is cleared by clear.
4. Reset asserted (reset=0) at handshake 4 -> all outputs 0 immediately (asynchronous); after release, no stream until a fresh done.
5. In FIN with done still high -> no second rd_en. Pulse clear with done high -> IDLE, then rd_en pulses again one cycle later and a full stream repeats.
6. clear asserted mid-STREAM at idx=6 -> out_valid=0 next cycle, stream_done stays 0, out_idx=0.
